port_extend_pipe: RTL and testbench

PORT_EXTEND_PIPE -- requirements
Module: port_extend_pipe

---
 rtl/port_extend_pipe.sv | 79 +++++++
 tb/tb_port_extend_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/port_extend_pipe.sv
// Narrow-to-wide sample FIFO: each sample is sign/zero extended at push time
// and stored extended, so later changes of in_w1/in_signed do not affect it.
module port_extend_pipe #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_w1,
  input  logic                       in_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 neg_count
);

  localparam int AW = $clog2(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic             sign_bit;
  logic [OUT_W-1:0] ext;

  assign in_ready  = (level < (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sign_bit = in_w1 ? in_data[0] : in_data[IN_W-1];
    ext      = '0;
    if (in_w1) begin
      ext = in_signed ? {OUT_W{in_data[0]}} : {{(OUT_W-1){1'b0}}, in_data[0]};
    end else begin
      ext = {{(OUT_W-IN_W){in_signed & in_data[IN_W-1]}}, in_data};
    end
  end

  // Storage is not reset; entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      neg_count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (push && in_signed && sign_bit && (neg_count != 8'hFF)) begin
        neg_count <= neg_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_port_extend_pipe.sv
// Directed bench for port_extend_pipe with hand-computed expected values.
module tb_port_extend_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       in_w1;
  logic       in_signed;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] level;
  logic [7:0] neg_count;

  int checks = 0;
  int errors = 0;

  port_extend_pipe #(.IN_W(2), .OUT_W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_w1     (in_w1),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .neg_count (neg_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 2'b00; in_w1 = 1'b0;
    in_signed = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_neg", 32'(neg_count), 0);

    // 1-bit signed source with bit0=1 -> all ones
    in_valid = 1'b1; in_w1 = 1'b1; in_signed = 1'b1; in_data = 2'b01;
    chk("no_same_cycle", 32'(out_valid), 0);
    step();
    in_valid = 1'b0; in_w1 = 1'b0; in_signed = 1'b0;
    chk("w1s_valid", 32'(out_valid), 1);
    chk("w1s_data", 32'(out_data), 4'hF);
    chk("w1s_neg", 32'(neg_count), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("w1s_pop_level", 32'(level), 0);
    chk("w1s_pop_data", 32'(out_data), 0);

    // 1-bit unsigned source ignores bit1
    in_valid = 1'b1; in_w1 = 1'b1; in_signed = 1'b0; in_data = 2'b11;
    step();
    in_valid = 1'b0;
    chk("w1u_data", 32'(out_data), 4'h1);
    chk("w1u_neg", 32'(neg_count), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // full-width signed then unsigned; attributes latched at push
    in_valid = 1'b1; in_w1 = 1'b0; in_signed = 1'b1; in_data = 2'b10;
    step();
    in_signed = 1'b0; in_data = 2'b10;
    step();
    in_valid = 1'b0; in_signed = 1'b1; in_w1 = 1'b1;
    chk("ord_level", 32'(level), 2);
    chk("ord_head0", 32'(out_data), 4'hE);
    chk("ord_neg", 32'(neg_count), 2);
    out_ready = 1'b1; step();
    chk("ord_head1", 32'(out_data), 4'h2);
    step();
    chk("ord_empty", 32'(level), 0);
    out_ready = 1'b0;

    // fill to full with in_valid held, 5th sample refused
    in_valid = 1'b1; in_w1 = 1'b0; in_signed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 2'(i);
      step();
    end
    chk("full_level", 32'(level), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    in_w1 = 1'b1; in_signed = 1'b1; in_data = 2'b01;
    step(); step();
    chk("full_5th_level", 32'(level), 4);
    chk("full_5th_neg", 32'(neg_count), 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("full_pop_no_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_level", 32'(level), 0);
    chk("drain_in_ready", 32'(in_ready), 1);

    // level 2, six cycles of simultaneous push and pop across the wrap
    in_valid = 1'b1; in_w1 = 1'b0; in_signed = 1'b0;
    in_data = 2'd0; step();
    in_data = 2'd1; step();
    out_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      in_data = 2'(k);
      chk("pp_level", 32'(level), 2);
      chk("pp_head", 32'(out_data), 32'((k - 2) % 4));
      step();
    end
    in_valid = 1'b0;
    chk("pp_tail0", 32'(out_data), 2);
    step();
    chk("pp_tail1", 32'(out_data), 3);
    step();
    chk("pp_empty", 32'(level), 0);
    out_ready = 1'b0;

    // level 3, neg_count 3, then reset with push and pop active
    in_valid = 1'b1; in_w1 = 1'b0; in_signed = 1'b1; in_data = 2'b10;
    step();
    in_signed = 1'b0; in_data = 2'b01; step();
    in_data = 2'b11; step();
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_neg", 32'(neg_count), 3);
    chk("pre_rst_head", 32'(out_data), 4'hE);
    rst = 1'b1; out_ready = 1'b1; in_signed = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst2_level", 32'(level), 0);
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out_data", 32'(out_data), 0);
    chk("rst2_neg", 32'(neg_count), 0);
    chk("rst2_in_ready", 32'(in_ready), 1);
    step();
    chk("rst2_hold", 32'(level), 0);

    // saturation of neg_count with streaming negative samples
    in_valid = 1'b1; in_w1 = 1'b1; in_signed = 1'b1; in_data = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 254; i++) step();
    chk("sat_254", 32'(neg_count), 254);
    step();
    chk("sat_255", 32'(neg_count), 255);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", 32'(neg_count), 255);
    chk("sat_level", 32'(level), 1);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
